// File: rtl/max_reduce_ctrl_uint16_pkg.sv
// Shared definitions for the max-reduce controller: FSM state encoding and
// the default data width used by the comparator.
package pimsynth_pkg;

  localparam int DEF_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/max_reduce_ctrl_uint16_if.sv
// Job/stream/result bus of the max-reduce controller.
// Optional macro ARGMAX_EN adds the out_idx signal.
interface max_reduce_ctrl_uint16_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic             busy;
`ifdef ARGMAX_EN
  logic [LEN_W-1:0] out_idx;

  modport master (output start, len, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_max, out_idx, busy);
  modport slave  (input  start, len, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_max, out_idx, busy);
`else
  modport master (output start, len, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_max, busy);
  modport slave  (input  start, len, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_max, busy);
`endif
endinterface

// File: rtl/max_reduce_ctrl_uint16_max_uint16.sv
// Unsigned two-input max: gt = (a > b), max = gt ? a : b.
// IMPL_TYPE 0: native relational compare; otherwise borrow of (b - a).
module max_uint16
  import pimsynth_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic [WIDTH-1:0] max
);

  generate
    if (IMPL_TYPE == 0) begin : g_rel
      assign gt = (a > b);
    end else begin : g_sub
      logic [WIDTH:0] diff;
      assign diff = {1'b0, b} - {1'b0, a};
      // a borrow always leaves a nonzero difference, so the reduction
      // does not change the result; it only keeps every diff bit in use
      assign gt = diff[WIDTH] & (|diff);
    end
  endgenerate

  assign max = gt ? a : b;

endmodule

// File: rtl/max_reduce_ctrl_uint16.sv
// Max-reduce sequencer: takes a job (start+len), folds len unsigned beats
// through one shared comparator, then offers the maximum on a valid/ready
// result beat. Optional macro ARGMAX_EN adds first-argmax tracking (out_idx).
module max_reduce_ctrl_uint16
  import pimsynth_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LEN_W     = 8,
  parameter int IMPL_TYPE = 0
) (
  input logic                     clk,
  input logic                     rst,
  max_reduce_ctrl_uint16_if.slave bus
);

  state_t           state;
  logic [LEN_W-1:0] cnt, len_q;
  logic [WIDTH-1:0] acc, res_max, cmp_max, nxt;
  logic             gt, beat, first, last;

  assign beat  = bus.in_valid && (state == ST_ACCUM);
  assign first = (cnt == '0);
  // cnt peaks at len-1 on the terminal beat, so it never wraps
  assign last  = (cnt == len_q - LEN_W'(1));
  // beat 0 seeds the accumulator; ties keep acc so the first max wins
  assign nxt   = first ? bus.in_data : cmp_max;

  max_uint16 #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_cmp (
    .a   (bus.in_data),
    .b   (acc),
    .gt  (gt),
    .max (cmp_max)
  );

  // FSM, beat counter, running max and held result
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      acc     <= '0;
      res_max <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          if (bus.len != '0) begin
            state <= ST_ACCUM;
            len_q <= bus.len;
            cnt   <= '0;
          end else begin
            state   <= ST_DONE;
            acc     <= '0;
            res_max <= '0;
          end
        end
        ST_ACCUM: if (beat) begin
          acc <= nxt;
          cnt <= cnt + LEN_W'(1);
          if (last) begin
            state   <= ST_DONE;
            res_max <= nxt;
          end
        end
        ST_DONE: if (bus.out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ARGMAX_EN
  logic [LEN_W-1:0] idx, res_idx, idx_nxt;

  assign idx_nxt = first ? '0 : (gt ? cnt : idx);

  // argmax follows the same gt that updates acc; only strict wins move it
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      res_idx <= '0;
    end else if (state == ST_IDLE && bus.start && bus.len == '0) begin
      idx     <= '0;
      res_idx <= '0;
    end else if (beat) begin
      idx <= idx_nxt;
      if (last) res_idx <= idx_nxt;
    end
  end

  assign bus.out_idx = res_idx;
`else
  // without ARGMAX_EN only the maximum value is tracked
`endif

  assign bus.in_ready  = (state == ST_ACCUM);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_max   = res_max;

endmodule
